// File: rtl/commonlib_demuxn_reg.sv
// commonlib_demuxn_reg: registered 1-to-N valid/ready stream demultiplexer
// with a one-entry holding register per lane and out-of-range drop counting.
module commonlib_demuxn_reg #(
  parameter int N     = 5,
  parameter int width = 32,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [width-1:0] in_data,
  input  logic [SELW-1:0]  in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_data [N-1:0],
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [7:0]       drop_count,
  output logic             drop_pulse
);

  logic [N-1:0] sel_hot;
  logic [N-1:0] stall;
  logic [N-1:0] load;
  logic [N-1:0] drain;
  logic         hit;
  logic         accept;
  logic         drop;

  // One-hot decode; an out-of-range select matches no lane.
  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < N; i++) begin
      sel_hot[i] = (in_sel == SELW'(i));
    end
  end

  assign hit      = |sel_hot;
  assign stall    = sel_hot & out_valid & ~out_ready;
  assign in_ready = ~|stall;
  assign accept   = in_valid & in_ready;
  assign load     = sel_hot & {N{accept}};
  assign drain    = out_valid & out_ready;
  assign drop     = accept & ~hit;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_valid <= '0;
      for (int i = 0; i < N; i++) begin
        out_data[i] <= '0;
      end
    end else begin
      // A load wins over a drain, so a full lane can refill with no bubble.
      out_valid <= load | (out_valid & ~drain);
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          out_data[i] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule
